// File: rtl/dp_hazard_controller_pkg.sv
// rtl/dp_hazard_controller_pkg.sv - shared types and constants for the hazard controller
package skylark_hazard_pkg;

    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MDU_BUSY = 1'b1
    } hz_state_e;

    // Forwarding select encoding for the EX operand muxes
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/dp_hazard_controller_if.sv
// rtl/dp_hazard_controller_if.sv - pipeline-to-hazard-controller signal bundle
interface dp_hazard_controller_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
);
    logic [REG_AW-1:0] i_rs1_d;
    logic [REG_AW-1:0] i_rs2_d;
    logic [REG_AW-1:0] i_rs1_e;
    logic [REG_AW-1:0] i_rs2_e;
    logic [REG_AW-1:0] i_rd_e;
    logic [REG_AW-1:0] i_rd_m;
    logic [REG_AW-1:0] i_rd_w;
    logic              i_load_e;
    logic              i_reg_write_m;
    logic              i_reg_write_w;
    logic              i_pc_src_e;
    logic              i_mdu_start_e;
    logic              i_mdu_done_e;
    logic              i_imem_ready_f;
    logic              o_stall_f;
    logic              o_stall_d;
    logic              o_flush_d;
    logic              o_stall_e;
    logic              o_flush_e;
    logic              o_flush_m;
    logic [1:0]        o_forward_a_e;
    logic [1:0]        o_forward_b_e;
    logic              o_mdu_timeout;
    logic [PERF_W-1:0] o_stall_cnt;
    logic [PERF_W-1:0] o_flush_cnt;

    // Pipeline side: drives hazard sources, receives stall/flush/forward controls
    modport master (
        output i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w,
        output i_load_e, i_reg_write_m, i_reg_write_w, i_pc_src_e,
        output i_mdu_start_e, i_mdu_done_e, i_imem_ready_f,
        input  o_stall_f, o_stall_d, o_flush_d, o_stall_e, o_flush_e, o_flush_m,
        input  o_forward_a_e, o_forward_b_e, o_mdu_timeout, o_stall_cnt, o_flush_cnt
    );

    // Controller side
    modport slave (
        input  i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w,
        input  i_load_e, i_reg_write_m, i_reg_write_w, i_pc_src_e,
        input  i_mdu_start_e, i_mdu_done_e, i_imem_ready_f,
        output o_stall_f, o_stall_d, o_flush_d, o_stall_e, o_flush_e, o_flush_m,
        output o_forward_a_e, o_forward_b_e, o_mdu_timeout, o_stall_cnt, o_flush_cnt
    );

endinterface

// File: rtl/dp_hazard_controller_forward_unit.sv
// rtl/dp_hazard_controller_forward_unit.sv - combinational EX operand forwarding selects
module dp_forward_unit
    import skylark_hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs1_e,
    input  logic [REG_AW-1:0] i_rs2_e,
    input  logic [REG_AW-1:0] i_rd_m,
    input  logic [REG_AW-1:0] i_rd_w,
    input  logic              i_reg_write_m,
    input  logic              i_reg_write_w,
    output logic [1:0]        o_forward_a_e,
    output logic [1:0]        o_forward_b_e
);

    // x0 is never forwarded; the younger M result beats the older W result
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != '0) begin
            if (i_reg_write_m && (i_rd_m == src))
                sel = FWD_M;
            else if (i_reg_write_w && (i_rd_w == src))
                sel = FWD_W;
        end
        return sel;
    endfunction

    // Select operand sources for both EX inputs
    always_comb begin
        o_forward_a_e = fwd_sel(i_rs1_e);
        o_forward_b_e = fwd_sel(i_rs2_e);
    end

endmodule

// File: rtl/dp_hazard_controller.sv
// rtl/dp_hazard_controller.sv - 5-stage pipeline stall/flush/forward sequencer (optional HAZ_PERF_CNT_EN perf counters)
module dp_hazard_controller
    import skylark_hazard_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int MDU_MAX_CYCLES = 64,
    parameter int PERF_W         = 32
) (
    input logic             clk,
    input logic             reset,
    dp_hazard_controller_if.slave hz
);

    localparam int         WD_W        = $clog2(MDU_MAX_CYCLES);
    localparam logic [0:0] ST_RUN      = HZ_RUN;
    localparam logic [0:0] ST_MDU_BUSY = HZ_MDU_BUSY;

    logic [0:0]      r_state;
    logic            r_redir_pend;
    logic [WD_W-1:0] r_wdog;
    logic            r_mdu_timeout;

    logic       w_lw_stall;
    logic       w_run;
    logic       w_stall_f, w_stall_d, w_stall_e;
    logic       w_flush_d, w_flush_e, w_flush_m;
    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_run      = (r_state == ST_RUN);
    assign w_lw_stall = hz.i_load_e && (hz.i_rd_e != '0) &&
                        ((hz.i_rs1_d == hz.i_rd_e) || (hz.i_rs2_d == hz.i_rd_e));

    dp_forward_unit #(.REG_AW(REG_AW)) u_fwd (
        .i_rs1_e       (hz.i_rs1_e),
        .i_rs2_e       (hz.i_rs2_e),
        .i_rd_m        (hz.i_rd_m),
        .i_rd_w        (hz.i_rd_w),
        .i_reg_write_m (hz.i_reg_write_m),
        .i_reg_write_w (hz.i_reg_write_w),
        .o_forward_a_e (w_fwd_a),
        .o_forward_b_e (w_fwd_b)
    );

    // Prioritised hazard resolution; the MDU done cycle falls through to the ordinary checks
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_m = 1'b0;
        if (!w_run && !hz.i_mdu_done_e) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_flush_m = 1'b1;
        end else if (w_run && hz.i_pc_src_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_run && hz.i_mdu_start_e && !hz.i_mdu_done_e) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_flush_m = 1'b1;
        end else if (w_lw_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (!hz.i_imem_ready_f) begin
            w_stall_f = 1'b1;
            w_flush_d = 1'b1;
        end
        // First fetch after a redirect that missed the I-mem is stale
        if (r_redir_pend && hz.i_imem_ready_f)
            w_flush_d = 1'b1;
        if (w_flush_d)
            w_stall_d = 1'b0;
        if (w_flush_e)
            w_stall_e = 1'b0;
    end

    // Reset forces the pipeline to drain: no stalls, all bubble-inserting flushes on
    always_comb begin
        hz.o_stall_f     = reset ? 1'b0 : w_stall_f;
        hz.o_stall_d     = reset ? 1'b0 : w_stall_d;
        hz.o_stall_e     = reset ? 1'b0 : w_stall_e;
        hz.o_flush_d     = reset | w_flush_d;
        hz.o_flush_e     = reset | w_flush_e;
        hz.o_flush_m     = reset | w_flush_m;
        hz.o_forward_a_e = reset ? FWD_REG : w_fwd_a;
        hz.o_forward_b_e = reset ? FWD_REG : w_fwd_b;
        hz.o_mdu_timeout = r_mdu_timeout;
    end

    // MDU busy tracking with watchdog, and redirect-pending bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_redir_pend  <= 1'b0;
            r_wdog        <= '0;
            r_mdu_timeout <= 1'b0;
        end else begin
            r_mdu_timeout <= 1'b0;
            if (w_run) begin
                r_wdog <= '0;
                if (!hz.i_pc_src_e && hz.i_mdu_start_e && !hz.i_mdu_done_e)
                    r_state <= ST_MDU_BUSY;
            end else if (hz.i_mdu_done_e) begin
                r_state <= ST_RUN;
                r_wdog  <= '0;
            end else if (r_wdog == WD_W'(MDU_MAX_CYCLES - 1)) begin
                r_state       <= ST_RUN;
                r_wdog        <= '0;
                r_mdu_timeout <= 1'b1;
            end else begin
                r_wdog <= r_wdog + WD_W'(1);
            end

            if (w_run && hz.i_pc_src_e)
                r_redir_pend <= !hz.i_imem_ready_f;
            else if (hz.i_imem_ready_f)
                r_redir_pend <= 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    // Saturating counts of fetch-stall and decode-flush cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f && (r_stall_cnt != {PERF_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_d && (r_flush_cnt != {PERF_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign hz.o_stall_cnt = r_stall_cnt;
    assign hz.o_flush_cnt = r_flush_cnt;
`else
    assign hz.o_stall_cnt = {PERF_W{1'b0}};
    assign hz.o_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule
